// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC sweep controller and its statistics accumulator.
package tdc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_SETTLE,
    ST_DONE
  } sweep_state_e;

  localparam int TIMEOUT_DEFAULT = 15;
  localparam int SETTLE_DEFAULT  = 2;

  function automatic int hw_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/tdc_stats_accum.sv
// Running sum / min / max / count of Hamming-weight samples, with clamping to the line length.
module tdc_stats_accum
  import tdc_pkg::*;
#(
  parameter int  N     = 64,
  parameter int  CNT_W = 8,
  localparam int HW_W  = hw_width(N),
  localparam int SUM_W = HW_W + CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             accept,
  input  logic [HW_W-1:0]  hw,
  output logic [SUM_W-1:0] sum,
  output logic [HW_W-1:0]  hw_min,
  output logic [HW_W-1:0]  hw_max,
  output logic [CNT_W-1:0] count
);

  localparam logic [HW_W-1:0] HW_FULL = HW_W'(N);

  logic [HW_W-1:0]  hw_clamped;
  logic [SUM_W-1:0] sum_d, sum_q;
  logic [HW_W-1:0]  min_d, min_q;
  logic [HW_W-1:0]  max_d, max_q;
  logic [CNT_W-1:0] count_d, count_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hw_clamped = (hw > HW_FULL) ? HW_FULL : hw;
    sum_d      = sum_q;
    min_d      = min_q;
    max_d      = max_q;
    count_d    = count_q;
    if (clear) begin
      sum_d   = '0;
      min_d   = HW_FULL;
      max_d   = '0;
      count_d = '0;
    end else if (accept) begin
      sum_d   = sum_q + SUM_W'(hw_clamped);
      count_d = count_q + CNT_W'(1);
      if (hw_clamped < min_q) min_d = hw_clamped;
      if (hw_clamped > max_q) max_d = hw_clamped;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      min_q   <= HW_FULL;
      max_q   <= '0;
      count_q <= '0;
    end else begin
      sum_q   <= sum_d;
      min_q   <= min_d;
      max_q   <= max_d;
      count_q <= count_d;
    end
  end

  assign sum    = sum_q;
  assign hw_min = min_q;
  assign hw_max = max_q;
  assign count  = count_q;

endmodule

// File: rtl/tdc_sweep_ctrl.sv
// Sweep initiator: launches TDC measurements, waits for each result with a timeout,
// and feeds accepted samples into the statistics accumulator.
module tdc_sweep_ctrl
  import tdc_pkg::*;
#(
  parameter int  N       = 64,
  parameter int  CNT_W   = 8,
  parameter int  TIMEOUT = TIMEOUT_DEFAULT,
  parameter int  SETTLE  = SETTLE_DEFAULT,
  localparam int HW_W    = hw_width(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_W-1:0]      n_samples,
  output logic                  tdc_en,
  output logic                  tdc_val_in,
  output logic                  tdc_pg_tog,
  input  logic [HW_W-1:0]       tdc_hw,
  input  logic                  tdc_val_out,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [HW_W+CNT_W-1:0] sum,
  output logic [HW_W-1:0]       hw_min,
  output logic [HW_W-1:0]       hw_max,
  output logic [CNT_W-1:0]      sample_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  sweep_state_e     state_d, state_q;
  logic [CNT_W-1:0] n_d, n_q;
  logic [TMO_W-1:0] tmo_d, tmo_q;
  logic [SET_W-1:0] set_d, set_q;
  logic             err_d, err_q;
  logic             pg_d, pg_q;
  logic             val_in_q, done_q, busy_q;
  logic             stats_clear, stats_accept;

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    tmo_d        = tmo_q;
    set_d        = set_q;
    err_d        = err_q;
    stats_clear  = 1'b0;
    stats_accept = 1'b0;
    // Abort wins over everything, including a result arriving in the same cycle.
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          n_d         = n_samples;
          err_d       = 1'b0;
          stats_clear = 1'b1;
          state_d     = (n_samples == '0) ? ST_DONE : ST_LAUNCH;
        end
        ST_LAUNCH: begin
          tmo_d   = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (tdc_val_out) begin
            stats_accept = 1'b1;
            if (sample_cnt + CNT_W'(1) == n_q) begin
              state_d = ST_DONE;
            end else if (SETTLE == 0) begin
              state_d = ST_LAUNCH;
            end else begin
              set_d   = '0;
              state_d = ST_SETTLE;
            end
          end else if (int'(tmo_q) >= TIMEOUT - 1) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        ST_SETTLE: begin
          if (int'(set_q) >= SETTLE - 1) state_d = ST_LAUNCH;
          else                           set_d   = set_q + SET_W'(1);
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
    pg_d = pg_q ^ (state_d == ST_LAUNCH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      tmo_q    <= '0;
      set_q    <= '0;
      err_q    <= 1'b0;
      pg_q     <= 1'b0;
      val_in_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      tmo_q    <= tmo_d;
      set_q    <= set_d;
      err_q    <= err_d;
      pg_q     <= pg_d;
      val_in_q <= (state_d == ST_LAUNCH);
      done_q   <= (state_d == ST_DONE);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  tdc_stats_accum #(.N(N), .CNT_W(CNT_W)) u_stats (
    .clk    (clk),
    .rst    (rst),
    .clear  (stats_clear),
    .accept (stats_accept),
    .hw     (tdc_hw),
    .sum    (sum),
    .hw_min (hw_min),
    .hw_max (hw_max),
    .count  (sample_cnt)
  );

  assign tdc_en      = busy_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign tdc_val_in  = val_in_q;
  assign tdc_pg_tog  = pg_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_tdc_sweep_ctrl.sv
// Self-checking bench for tdc_sweep_ctrl: a tdc_top responder model, a table of directed
// sweeps, hand-written abort/reset/spurious sequences and randomized sweeps against a model.
module tb_tdc_sweep_ctrl;

  localparam int N       = 64;
  localparam int CNT_W   = 8;
  localparam int HW_W    = 7;
  localparam int TIMEOUT = 15;
  localparam int SETTLE  = 2;

  logic                  clk, rst, start, abort;
  logic [CNT_W-1:0]      n_samples;
  logic                  tdc_en, tdc_val_in, tdc_pg_tog;
  logic [HW_W-1:0]       tdc_hw;
  logic                  tdc_val_out;
  logic                  busy, done, timeout_err;
  logic [HW_W+CNT_W-1:0] sum;
  logic [HW_W-1:0]       hw_min, hw_max;
  logic [CNT_W-1:0]      sample_cnt;

  tdc_sweep_ctrl #(.N(N), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .n_samples(n_samples),
    .tdc_en(tdc_en), .tdc_val_in(tdc_val_in), .tdc_pg_tog(tdc_pg_tog),
    .tdc_hw(tdc_hw), .tdc_val_out(tdc_val_out), .busy(busy), .done(done),
    .timeout_err(timeout_err), .sum(sum), .hw_min(hw_min), .hw_max(hw_max),
    .sample_cnt(sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n; int ans; logic [3:0][6:0] hw; int lat; bit lat_rand; bit spur; bit poke;
    int e_sum; int e_min; int e_max; int e_cnt; int e_err; int e_vin;
  } vec_t;

  int n_vec = 0, n_bad = 0;
  int cyc = 0;
  int vin_cnt, done_cnt, pg_changes, gap_bad;
  int last_vin_cyc, last_vout_cyc, done_cyc, pend_at;
  bit vout_seen, spur_en;
  logic pg_prev;
  logic [6:0] pend_hw;
  logic [6:0] hw_q[$];
  int lat_q[$];
  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One clock: observe DUT outputs #1 after the edge, then drive the tdc_top response.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (tdc_val_in) begin
      vin_cnt++;
      last_vin_cyc = cyc;
      if (vout_seen && (cyc - last_vout_cyc) != SETTLE + 1) gap_bad++;
      if (hw_q.size() > 0) begin
        pend_hw = hw_q.pop_front();
        pend_at = cyc + lat_q.pop_front();
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (tdc_pg_tog !== pg_prev) pg_changes++;
    pg_prev     = tdc_pg_tog;
    tdc_val_out = (pend_at == cyc);
    tdc_hw      = tdc_val_out ? pend_hw : 7'($urandom_range(0, 127));
    if (tdc_val_out) begin
      last_vout_cyc = cyc;
      vout_seen     = 1'b1;
    end else if (spur_en && last_vout_cyc == cyc - 1) begin
      tdc_val_out = 1'b1;
      tdc_hw      = 7'd1;
    end
  endtask

  task automatic sweep_reset();
    vin_cnt = 0; done_cnt = 0; pg_changes = 0; gap_bad = 0;
    pg_prev = tdc_pg_tog; pend_at = -1; done_cyc = -1;
    last_vin_cyc = -100; last_vout_cyc = -100; vout_seen = 1'b0; spur_en = 1'b0;
    hw_q.delete(); lat_q.delete();
  endtask

  function automatic vec_t mk(int n, int ans, int h0, int h1, int h2, int h3, int lat,
                              bit spur, bit poke, int es, int emn, int emx, int ec, int ee, int ev);
    vec_t v;
    v.n = n; v.ans = ans; v.lat = lat; v.lat_rand = 1'b0; v.spur = spur; v.poke = poke;
    v.hw[0] = 7'(h0); v.hw[1] = 7'(h1); v.hw[2] = 7'(h2); v.hw[3] = 7'(h3);
    v.e_sum = es; v.e_min = emn; v.e_max = emx; v.e_cnt = ec; v.e_err = ee; v.e_vin = ev;
    return v;
  endfunction

  // Reference: statistics over the samples that tdc_top actually answers.
  function automatic vec_t model(vec_t v);
    int k, h;
    k = (v.ans < v.n) ? v.ans : v.n;
    v.e_sum = 0; v.e_min = N; v.e_max = 0; v.e_cnt = k;
    v.e_err = (v.n != 0 && v.ans < v.n) ? 1 : 0;
    for (int i = 0; i < k; i++) begin
      h = (int'(v.hw[i]) > N) ? N : int'(v.hw[i]);
      v.e_sum += h;
      if (h < v.e_min) v.e_min = h;
      if (h > v.e_max) v.e_max = h;
    end
    v.e_vin = (v.n == 0) ? 0 : ((k < v.n) ? k + 1 : v.n);
    return v;
  endfunction

  task automatic run_sweep(input vec_t v, input string tag);
    int s;
    sweep_reset();
    spur_en = v.spur;
    for (int i = 0; i < v.ans && i < 4; i++) begin
      hw_q.push_back(v.hw[i]);
      lat_q.push_back(v.lat_rand ? int'($urandom_range(1, TIMEOUT)) : v.lat);
    end
    s = cyc;
    n_samples = CNT_W'(v.n);
    start = 1'b1;
    step();
    start = 1'b0;
    while (done_cnt == 0 && cyc - s < 600) begin
      start = v.poke && (cyc == s + 4);
      if (start) n_samples = CNT_W'(1);
      step();
    end
    start = 1'b0;
    repeat (3) step();
    check({tag, ".done_pulses"}, done_cnt, 1);
    check({tag, ".sum"}, sum, v.e_sum);
    check({tag, ".hw_min"}, hw_min, v.e_min);
    check({tag, ".hw_max"}, hw_max, v.e_max);
    check({tag, ".sample_cnt"}, sample_cnt, v.e_cnt);
    check({tag, ".timeout_err"}, timeout_err, v.e_err);
    check({tag, ".val_in_pulses"}, vin_cnt, v.e_vin);
    check({tag, ".pg_toggles"}, pg_changes, v.e_vin);
    check({tag, ".settle_gap_errs"}, gap_bad, 0);
    check({tag, ".busy_after"}, busy, 0);
    if (v.n == 0)          check({tag, ".done_cycle"}, done_cyc, s + 1);
    else if (v.e_err != 0) check({tag, ".done_cycle"}, done_cyc, last_vin_cyc + 1 + TIMEOUT);
    else                   check({tag, ".done_cycle"}, done_cyc, last_vout_cyc + 1);
  endtask

  // Abort d cycles after the second launch; d == 5 coincides with that launch's result.
  task automatic abort_run(input int d, input string tag);
    int s, s2;
    sweep_reset();
    hw_q.push_back(7'd30); lat_q.push_back(3);
    hw_q.push_back(7'd99); lat_q.push_back(5);
    s = cyc;
    n_samples = CNT_W'(3);
    start = 1'b1;
    step();
    start = 1'b0;
    while (vin_cnt < 2 && cyc - s < 200) step();
    check({tag, ".second_launch"}, vin_cnt, 2);
    s2 = cyc;
    while (cyc < s2 + d) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check({tag, ".busy"}, busy, 0);
    check({tag, ".tdc_en"}, tdc_en, 0);
    repeat (8) step();
    check({tag, ".done_pulses"}, done_cnt, 0);
    check({tag, ".sum"}, sum, 30);
    check({tag, ".sample_cnt"}, sample_cnt, 1);
    check({tag, ".hw_max"}, hw_max, 30);
    check({tag, ".timeout_err"}, timeout_err, 0);
  endtask

  task automatic reset_in_settle();
    int s;
    sweep_reset();
    for (int i = 0; i < 4; i++) begin
      hw_q.push_back(7'(40 + i));
      lat_q.push_back(2);
    end
    s = cyc;
    n_samples = CNT_W'(4);
    start = 1'b1;
    step();
    start = 1'b0;
    while (!vout_seen && cyc - s < 100) step();
    step();
    check("rst_mid.pre_sum", sum, 40);
    check("rst_mid.pre_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid.busy", busy, 0);
    check("rst_mid.tdc_en", tdc_en, 0);
    check("rst_mid.pg_tog", tdc_pg_tog, 0);
    check("rst_mid.sum", sum, 0);
    check("rst_mid.hw_min", hw_min, N);
    check("rst_mid.sample_cnt", sample_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    sweep_reset();
    step();
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; start = 1'b0; abort = 1'b0; n_samples = '0;
    tdc_val_out = 1'b0; tdc_hw = '0;
    sweep_reset();
    #12;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.tdc_en", tdc_en, 0);
    check("reset.val_in", tdc_val_in, 0);
    check("reset.pg_tog", tdc_pg_tog, 0);
    check("reset.timeout_err", timeout_err, 0);
    check("reset.sum", sum, 0);
    check("reset.hw_min", hw_min, N);
    check("reset.hw_max", hw_max, 0);
    check("reset.sample_cnt", sample_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    //             n ans  h0  h1  h2  h3 lat sp pk  sum min max cnt err vin
    tbl[0] = mk(1, 1, 17,  0,  0,  0,  3, 0, 0,  17, 17, 17, 1, 0, 1);
    tbl[1] = mk(4, 4, 10, 40,  3, 64,  3, 0, 0, 117,  3, 64, 4, 0, 4);
    tbl[2] = mk(3, 1, 20,  0,  0,  0,  3, 0, 0,  20, 20, 20, 1, 1, 2);
    tbl[3] = mk(0, 0,  0,  0,  0,  0,  3, 0, 0,   0, 64,  0, 0, 0, 0);
    tbl[4] = mk(4, 4,  5,  6,  7,  8,  2, 0, 1,  26,  5,  8, 4, 0, 4);
    tbl[5] = mk(1, 1, 33,  0,  0,  0, 15, 0, 0,  33, 33, 33, 1, 0, 1);
    tbl[6] = mk(1, 1, 33,  0,  0,  0, 16, 0, 0,   0, 64,  0, 0, 1, 1);
    tbl[7] = mk(2, 2, 50, 60,  0,  0,  2, 1, 0, 110, 50, 60, 2, 0, 2);
    tbl[8] = mk(3, 3,  0,  0,  0,  0,  1, 0, 0,   0,  0,  0, 3, 0, 3);
    tbl[9] = mk(2, 2, 70,  5,  0,  0,  4, 0, 0,  69,  5, 64, 2, 0, 2);
    for (int i = 0; i < 10; i++) run_sweep(tbl[i], $sformatf("vec%0d", i));

    // A result strobe while idle must leave the last sweep's statistics alone.
    tdc_val_out = 1'b1;
    tdc_hw      = 7'd1;
    step();
    step();
    check("idle_spur.sum", sum, tbl[9].e_sum);
    check("idle_spur.hw_min", hw_min, tbl[9].e_min);
    check("idle_spur.sample_cnt", sample_cnt, tbl[9].e_cnt);
    check("idle_spur.busy", busy, 0);

    abort_run(2, "abort_wait");
    abort_run(5, "abort_vs_result");
    reset_in_settle();

    for (int r = 0; r < 25; r++) begin
      int n, ans;
      n   = $urandom_range(0, 4);
      ans = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : n;
      v = mk(n, ans, $urandom_range(0, 80), $urandom_range(0, 80), $urandom_range(0, 80),
             $urandom_range(0, 127), 1, 0, 0, 0, 0, 0, 0, 0, 0);
      v.lat_rand = 1'b1;
      v = model(v);
      run_sweep(v, $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
